// File: rtl/axis_pattern_gen.sv
// AXI4-Stream test-pattern source: NUM packets of LEN beats with a programmable
// inter-packet gap. The pattern is up/down count, Galois LFSR or constant.
//
// state | meaning
// IDLE  | waiting for cfg_start; config not latched
// SEND  | presenting beats; tvalid high
// GAP   | idle cycles between packets; tvalid low
module axis_pattern_gen #(
  parameter int          DATA_W    = 32,
  parameter int          CNT_W     = 32,
  parameter logic [31:0] LFSR_POLY = 32'h80200003
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                cfg_start,
  input  logic                cfg_stop,
  input  logic [1:0]          cfg_mode,
  input  logic                cfg_restart,
  input  logic [DATA_W-1:0]   cfg_seed,
  input  logic [DATA_W-1:0]   cfg_incr,
  input  logic [CNT_W-1:0]    cfg_len,
  input  logic [CNT_W-1:0]    cfg_num,
  input  logic [CNT_W-1:0]    cfg_gap,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  output logic                m_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                busy,
  output logic                done,
  output logic                cfg_err,
  output logic [CNT_W-1:0]    pkt_count
);

  localparam logic [DATA_W-1:0] POLY    = DATA_W'(LFSR_POLY);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t              state_q, state_d;
  logic [1:0]          mode_q;
  logic                restart_q;
  logic [DATA_W-1:0]   seed_q, incr_q, pat_q;
  logic [CNT_W-1:0]    len_q, num_q, gap_q;
  logic [CNT_W-1:0]    beat_q, gap_cnt_q, pkt_cnt_q;
  logic                stop_q, done_q, err_q;

  logic                hs, last_beat, end_run;
  logic [CNT_W-1:0]    pkt_inc;

  // LFSR lock-up avoidance: an all-zero seed is replaced by 1.
  function automatic logic [DATA_W-1:0] seed_eff(input logic [1:0] m,
                                                 input logic [DATA_W-1:0] s);
    return (m == 2'd2 && s == '0) ? DATA_W'(1) : s;
  endfunction

  function automatic logic [DATA_W-1:0] next_pat(input logic [1:0] m,
                                                 input logic [DATA_W-1:0] p,
                                                 input logic [DATA_W-1:0] inc);
    case (m)
      2'd0:    return p + inc;
      2'd1:    return p - inc;
      2'd2:    return (p >> 1) ^ (p[0] ? POLY : '0);
      default: return p;
    endcase
  endfunction

  assign hs        = m_axis_tvalid & m_axis_tready;
  assign last_beat = (beat_q == len_q - CNT_ONE);
  assign pkt_inc   = (&pkt_cnt_q) ? pkt_cnt_q : pkt_cnt_q + CNT_ONE;
  assign end_run   = stop_q | (num_q != '0 && pkt_inc == num_q);

  // State register.
  always_ff @(posedge aclk) begin
    if (areset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (cfg_start && cfg_len != '0) state_d = S_SEND;
      S_SEND: begin
        if (hs && last_beat) begin
          if (end_run)           state_d = S_IDLE;
          else if (gap_q != '0)  state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cfg_stop)                state_d = S_IDLE;
        else if (gap_cnt_q == '0)    state_d = S_SEND;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stream and status outputs decoded from state.
  always_comb begin
    m_axis_tvalid = (state_q == S_SEND);
    m_axis_tlast  = (state_q == S_SEND) && last_beat;
    busy          = (state_q != S_IDLE);
  end

  assign m_axis_tdata = pat_q;
  assign m_axis_tkeep = '1;
  assign done         = done_q;
  assign cfg_err      = err_q;
  assign pkt_count    = pkt_cnt_q;

  // Config latch, beat/gap counters, pattern and status pulses.
  always_ff @(posedge aclk) begin
    if (areset) begin
      mode_q    <= '0;
      restart_q <= 1'b0;
      seed_q    <= '0;
      incr_q    <= '0;
      len_q     <= '0;
      num_q     <= '0;
      gap_q     <= '0;
      pat_q     <= '0;
      beat_q    <= '0;
      gap_cnt_q <= '0;
      pkt_cnt_q <= '0;
      stop_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cfg_start) begin
            if (cfg_len == '0) begin
              err_q <= 1'b1;
            end else begin
              mode_q    <= cfg_mode;
              restart_q <= cfg_restart;
              seed_q    <= cfg_seed;
              incr_q    <= cfg_incr;
              len_q     <= cfg_len;
              num_q     <= cfg_num;
              gap_q     <= cfg_gap;
              pat_q     <= seed_eff(cfg_mode, cfg_seed);
              beat_q    <= '0;
              pkt_cnt_q <= '0;
              // start and stop together: send exactly one packet
              stop_q    <= cfg_stop;
            end
          end
        end
        S_SEND: begin
          if (cfg_stop) stop_q <= 1'b1;
          if (hs) begin
            if (last_beat) begin
              beat_q    <= '0;
              pkt_cnt_q <= pkt_inc;
              pat_q     <= restart_q ? seed_eff(mode_q, seed_q)
                                     : next_pat(mode_q, pat_q, incr_q);
              if (end_run)          done_q    <= 1'b1;
              else if (gap_q != '0) gap_cnt_q <= gap_q - CNT_ONE;
            end else begin
              beat_q <= beat_q + CNT_ONE;
              pat_q  <= next_pat(mode_q, pat_q, incr_q);
            end
          end
        end
        S_GAP: begin
          if (cfg_stop)              done_q    <= 1'b1;
          else if (gap_cnt_q != '0)  gap_cnt_q <= gap_cnt_q - CNT_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pattern_gen.sv
module tb_axis_pattern_gen;
  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          areset, cfg_start, cfg_stop, cfg_restart, m_axis_tready;
  logic [1:0]    cfg_mode;
  logic [DW-1:0] cfg_seed, cfg_incr, m_axis_tdata;
  logic [CW-1:0] cfg_len, cfg_num, cfg_gap, pkt_count;
  logic [DW/8-1:0] m_axis_tkeep;
  logic          m_axis_tlast, m_axis_tvalid, busy, done, cfg_err;

  always #5 clk = ~clk;

  axis_pattern_gen #(.DATA_W(DW), .CNT_W(CW)) dut (
    .aclk(clk), .areset(areset), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_mode(cfg_mode), .cfg_restart(cfg_restart), .cfg_seed(cfg_seed),
    .cfg_incr(cfg_incr), .cfg_len(cfg_len), .cfg_num(cfg_num), .cfg_gap(cfg_gap),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .busy(busy), .done(done),
    .cfg_err(cfg_err), .pkt_count(pkt_count)
  );

  int checks = 0, failures = 0;
  int cyc = 0, start_cyc = 0;
  int done_cnt = 0, err_cnt = 0, done_cyc = 0;
  logic [8:0] exp_q[$];
  int hs_cyc[$];
  bit sb_en = 1'b1;
  logic stall_q = 1'b0, stall_l = 1'b0;
  logic [7:0] stall_d = '0;
  logic [8:0] e;

  always @(posedge clk) cyc++;

  // Output monitor: scoreboard pop on handshake, backpressure stability.
  always @(negedge clk) begin
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (cfg_err) err_cnt++;
    if (sb_en && stall_q) begin
      checks++;
      assert (m_axis_tvalid === 1'b1 && m_axis_tdata === stall_d && m_axis_tlast === stall_l)
        else begin
          failures++;
          $error("FAIL stall_hold obs=%b/%h/%b exp=1/%h/%b", m_axis_tvalid, m_axis_tdata,
                 m_axis_tlast, stall_d, stall_l);
        end
    end
    if (m_axis_tvalid && m_axis_tready) begin
      hs_cyc.push_back(cyc);
      if (sb_en) begin
        checks++;
        assert (exp_q.size() != 0)
          else begin failures++; $error("FAIL sb_extra obs=%h exp=none", m_axis_tdata); end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checks++;
          assert ({m_axis_tlast, m_axis_tdata} === e)
            else begin
              failures++;
              $error("FAIL sb_beat obs=%b/%h exp=%b/%h", m_axis_tlast, m_axis_tdata, e[8], e[7:0]);
            end
        end
      end
    end
    stall_q = m_axis_tvalid & ~m_axis_tready & ~areset;
    stall_d = m_axis_tdata;
    stall_l = m_axis_tlast;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin failures++; $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp); end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] mdl_next(input logic [1:0] m, input logic [7:0] p,
                                          input logic [7:0] inc);
    case (m)
      2'd0:    return p + inc;
      2'd1:    return p - inc;
      2'd2:    return {1'b0, p[7:1]} ^ (p[0] ? 8'h03 : 8'h00);
      default: return p;
    endcase
  endfunction

  task automatic push_run(input logic [1:0] m, input logic [7:0] seed, input logic [7:0] inc,
                          input bit rst, input int len, input int npk);
    logic [7:0] s0, p;
    s0 = (m == 2'd2 && seed == 8'h00) ? 8'h01 : seed;
    p  = s0;
    for (int k = 0; k < npk; k++)
      for (int b = 0; b < len; b++) begin
        exp_q.push_back({(b == len - 1), p});
        p = (b == len - 1 && rst) ? s0 : mdl_next(m, p, inc);
      end
  endtask

  task automatic do_start(input logic [1:0] m, input logic [7:0] seed, input logic [7:0] inc,
                          input bit rst, input int len, input int num, input int gap,
                          input bit stp);
    cfg_mode = m; cfg_seed = seed; cfg_incr = inc; cfg_restart = rst;
    cfg_len = CW'(len); cfg_num = CW'(num); cfg_gap = CW'(gap);
    cfg_start = 1'b1; cfg_stop = stp;
    hs_cyc.delete();
    start_cyc = cyc;
    tick();
    cfg_start = 1'b0; cfg_stop = 1'b0;
  endtask

  task automatic wait_done(input int max, input bit rnd);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < max && done_cnt == d0; i++) begin
      if (rnd) m_axis_tready = 1'($urandom_range(0, 1));
      tick();
    end
    m_axis_tready = 1'b1;
    chk("done_seen", 32'(done_cnt != d0), 32'd1);
    tick(); tick();
    chk("done_width", done_cnt, d0 + 1);
  endtask

  task automatic wait_data(input logic [7:0] v, input int max);
    int i;
    for (i = 0; i < max && !(m_axis_tvalid && m_axis_tdata == v); i++) tick();
    chk("wait_data", 32'(i < max), 32'd1);
  endtask

  int e0;

  initial begin
    areset = 1'b1; cfg_start = 0; cfg_stop = 0; cfg_mode = 0; cfg_restart = 0;
    cfg_seed = 0; cfg_incr = 0; cfg_len = 0; cfg_num = 0; cfg_gap = 0; m_axis_tready = 1'b1;
    repeat (3) tick();
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tkeep", m_axis_tkeep, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done_err", {done, cfg_err}, 0);
    chk("rst_pkt", pkt_count, 0);
    areset = 1'b0;
    tick();

    // T1: up-count, two packets of 4, no gap
    for (int i = 0; i < 8; i++) exp_q.push_back({(i == 3 || i == 7), 8'(i)});
    do_start(2'd0, 8'd0, 8'd1, 1'b0, 4, 2, 0, 1'b0);
    chk("t1_busy", busy, 1);
    wait_done(50, 1'b0);
    chk("t1_sb_empty", exp_q.size(), 0);
    chk("t1_pkt", pkt_count, 2);
    chk("t1_beats", hs_cyc.size(), 8);
    chk("t1_latency", hs_cyc[0], start_cyc + 1);
    chk("t1_contig", hs_cyc[7] - hs_cyc[0], 7);
    chk("t1_done_lat", done_cyc, hs_cyc[7] + 1);

    // T2: single-beat packets with gap 2
    push_run(2'd0, 8'd10, 8'd5, 1'b0, 1, 3);
    do_start(2'd0, 8'd10, 8'd5, 1'b0, 1, 3, 2, 1'b0);
    wait_done(50, 1'b0);
    chk("t2_sb_empty", exp_q.size(), 0);
    chk("t2_beats", hs_cyc.size(), 3);
    chk("t2_gap1", hs_cyc[1] - hs_cyc[0], 3);
    chk("t2_gap2", hs_cyc[2] - hs_cyc[1], 3);
    chk("t2_done_lat", done_cyc, hs_cyc[2] + 1);
    chk("t2_pkt", pkt_count, 3);

    // T3: random backpressure
    push_run(2'd0, 8'd0, 8'd1, 1'b0, 8, 1);
    do_start(2'd0, 8'd0, 8'd1, 1'b0, 8, 1, 0, 1'b0);
    wait_done(300, 1'b1);
    chk("t3_sb_empty", exp_q.size(), 0);
    chk("t3_pkt", pkt_count, 1);

    // T4: down-count with wrap and seed reload; a start while busy is ignored
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({1'b0, 8'd2});
      exp_q.push_back({1'b0, 8'd255});
      exp_q.push_back({1'b1, 8'd252});
    end
    do_start(2'd1, 8'd2, 8'd3, 1'b1, 3, 2, 1, 1'b0);
    cfg_mode = 2'd0; cfg_seed = 8'd77; cfg_len = 1; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    wait_done(50, 1'b0);
    chk("t4_sb_empty", exp_q.size(), 0);
    chk("t4_pkt", pkt_count, 2);

    // T5: infinite run, stop at beat 2 of packet 5
    push_run(2'd0, 8'd0, 8'd1, 1'b0, 6, 5);
    do_start(2'd0, 8'd0, 8'd1, 1'b0, 6, 0, 0, 1'b0);
    wait_data(8'd26, 200);
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    wait_done(50, 1'b0);
    chk("t5_sb_empty", exp_q.size(), 0);
    chk("t5_pkt", pkt_count, 5);
    repeat (8) tick();
    chk("t5_no_more", hs_cyc.size(), 30);
    chk("t5_idle", {m_axis_tvalid, busy}, 0);

    // LFSR with zero seed
    push_run(2'd2, 8'd0, 8'd0, 1'b0, 4, 1);
    do_start(2'd2, 8'd0, 8'd0, 1'b0, 4, 1, 0, 1'b0);
    wait_done(50, 1'b0);
    chk("lfsr_sb_empty", exp_q.size(), 0);

    // start and stop together: exactly one packet
    push_run(2'd0, 8'd5, 8'd1, 1'b0, 2, 1);
    do_start(2'd0, 8'd5, 8'd1, 1'b0, 2, 0, 0, 1'b1);
    wait_done(50, 1'b0);
    chk("ss_sb_empty", exp_q.size(), 0);
    chk("ss_pkt", pkt_count, 1);

    // stop during GAP ends the run at once
    push_run(2'd0, 8'd0, 8'd1, 1'b0, 2, 1);
    do_start(2'd0, 8'd0, 8'd1, 1'b0, 2, 0, 5, 1'b0);
    for (int i = 0; i < 20 && !(busy && !m_axis_tvalid); i++) tick();
    chk("gs_in_gap", {busy, m_axis_tvalid}, 2'b10);
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    wait_done(2, 1'b0);
    chk("gs_beats", hs_cyc.size(), 2);
    chk("gs_pkt", pkt_count, 1);

    // T6: reset mid-packet, then start with len 0
    sb_en = 1'b0;
    do_start(2'd0, 8'd0, 8'd1, 1'b0, 5, 0, 0, 1'b0);
    wait_data(8'd8, 100);
    chk("t6_pkt_pre", pkt_count, 1);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    chk("t6_tvalid", m_axis_tvalid, 0);
    chk("t6_tlast", m_axis_tlast, 0);
    chk("t6_pkt", pkt_count, 0);
    chk("t6_busy", busy, 0);
    exp_q.delete();
    sb_en = 1'b1;
    e0 = err_cnt;
    do_start(2'd0, 8'd0, 8'd1, 1'b0, 0, 1, 0, 1'b0);
    tick();
    chk("t6_err", err_cnt, e0 + 1);
    chk("t6_err_busy", {busy, m_axis_tvalid}, 0);
    repeat (3) tick();
    chk("t6_err_width", err_cnt, e0 + 1);
    chk("t6_no_beats", hs_cyc.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
